// File: rtl/jk_bank_arbiter_if.sv
// jk_bank_arbiter_if: signal bundle between the JK bank arbiter, its
// requesters and the JK flop bank.
//   master : environment side (requesters and bank) - drives req/op/idx/q/clr_err
//   slave  : arbiter side - drives gnt/j/k/busy/done/done_id/err
// Widths must match the parameters of the jk_bank_arbiter instance.
interface jk_bank_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH),
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]       req;
    logic [2*N_REQ-1:0]     op;
    logic [IDX_W*N_REQ-1:0] idx;
    logic [WIDTH-1:0]       q;
    logic                   clr_err;
    logic [N_REQ-1:0]       gnt;
    logic [WIDTH-1:0]       j;
    logic [WIDTH-1:0]       k;
    logic                   busy;
    logic                   done;
    logic [ID_W-1:0]        done_id;
    logic                   err;

    modport master (
        output req, op, idx, q, clr_err,
        input  gnt, j, k, busy, done, done_id, err
    );

    modport slave (
        input  req, op, idx, q, clr_err,
        output gnt, j, k, busy, done, done_id, err
    );
endinterface

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin controller sharing a bank of WIDTH JK flops
// among N_REQ requesters. A granted request drives j/k of one bank bit for a
// single cycle (hold/clear/set/toggle), then reads q back to confirm.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous, active-low reset
//   bus    - jk_bank_arbiter_if.slave:
//            req/op/idx  requester inputs (op 00 hold, 01 clear, 10 set, 11 toggle)
//            q           bank outputs
//            clr_err     synchronous clear of err
//            gnt         one-hot grant pulse
//            j/k         registered bank inputs
//            busy        state not IDLE
//            done/done_id completion pulse and requester id
//            err         sticky result-mismatch / illegal-index flag
module jk_bank_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH),
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    jk_bank_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, APPLY, CHECK} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   w_q, w_d;
    logic [1:0]        op_q, op_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              old_q, old_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [WIDTH-1:0]  j_q, j_d;
    logic [WIDTH-1:0]  k_q, k_d;
    logic              done_q, done_d;
    logic [ID_W-1:0]   done_id_q, done_id_d;
    logic              err_q, err_d;

    // Round-robin search from ptr_q, plus decode of the winner's request
    logic              found;
    logic [ID_W-1:0]   win;
    logic [ID_W-1:0]   cand_id;
    int unsigned       cand;
    logic [1:0]        win_op;
    logic [IDX_W-1:0]  win_idx;
    logic [WIDTH-1:0]  win_j;
    logic [WIDTH-1:0]  win_k;

    always_comb begin
        found   = 1'b0;
        win     = '0;
        cand    = 0;
        cand_id = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand    = (32'(ptr_q) + i) % N_REQ;
            cand_id = ID_W'(cand);
            if (!found && bus.req[cand_id]) begin
                found = 1'b1;
                win   = cand_id;
            end
        end
        win_op  = bus.op[2*win +: 2];
        win_idx = bus.idx[IDX_W*win +: IDX_W];
        // An index >= WIDTH matches no bit, so nothing is driven
        win_j   = '0;
        win_k   = '0;
        for (int unsigned b = 0; b < WIDTH; b++) begin
            if (win_idx == IDX_W'(b)) begin
                win_j[b] = win_op[1];
                win_k[b] = win_op[0];
            end
        end
    end

    // Bank bit addressed by the captured index; idx_hit low for an illegal index
    logic q_sel;
    logic idx_hit;
    logic expect_q;

    always_comb begin
        q_sel   = 1'b0;
        idx_hit = 1'b0;
        for (int unsigned b = 0; b < WIDTH; b++) begin
            if (idx_q == IDX_W'(b)) begin
                q_sel   = bus.q[b];
                idx_hit = 1'b1;
            end
        end
        case (op_q)
            2'b00:   expect_q = old_q;
            2'b01:   expect_q = 1'b0;
            2'b10:   expect_q = 1'b1;
            default: expect_q = ~old_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        w_d       = w_q;
        op_d      = op_q;
        idx_d     = idx_q;
        old_d     = old_q;
        gnt_d     = '0;
        j_d       = '0;
        k_d       = '0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        err_d     = err_q;

        if (bus.clr_err) begin
            err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = APPLY;
                    ptr_d   = (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
                    gnt_d   = N_REQ'(1) << win;
                    w_d     = win;
                    op_d    = win_op;
                    idx_d   = win_idx;
                    // j/k are loaded on the grant edge so they are valid
                    // throughout APPLY and return to zero for CHECK
                    j_d     = win_j;
                    k_d     = win_k;
                end
            end
            APPLY: begin
                state_d = CHECK;
                old_d   = q_sel;
            end
            CHECK: begin
                state_d   = IDLE;
                done_d    = 1'b1;
                done_id_d = w_q;
                // Placed after the clear so a coincident error wins
                if (!idx_hit || (q_sel != expect_q)) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            w_q       <= '0;
            op_q      <= '0;
            idx_q     <= '0;
            old_q     <= 1'b0;
            gnt_q     <= '0;
            j_q       <= '0;
            k_q       <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            w_q       <= w_d;
            op_q      <= op_d;
            idx_q     <= idx_d;
            old_q     <= old_d;
            gnt_q     <= gnt_d;
            j_q       <= j_d;
            k_q       <= k_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            err_q     <= err_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.j       = j_q;
    assign bus.k       = k_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.err     = err_q;

endmodule

// File: doc/jk_bank_arbiter.md
# jk_bank_arbiter

Round-robin controller that shares a bank of WIDTH independent JK flip-flops among N_REQ requesters. Each granted request names one bank bit and an operation: hold, clear, set or toggle. The block drives that bit's j/k inputs for exactly one cycle, then reads the bank's q outputs back to confirm the result. It sits between the requesting control logic and the flop bank, and is the only driver of the bank's j/k inputs.

## Interface
- N_REQ, default 4: number of requesters; must be at least 2.
- WIDTH, default 8: number of JK flops in the bank; must be at least 2.
- IDX_W, default $clog2(WIDTH): width of each bit index.
- ID_W, default $clog2(N_REQ): width of the requester id.
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester request; held high until granted.
- op  in  2*N_REQ  per-requester op; 00 hold, 01 clear, 10 set, 11 toggle. Requester i uses bits [2i+1:2i].
- idx  in  IDX_W*N_REQ  per-requester target bit index.
- q  in  WIDTH  current q outputs of the bank.
- clr_err  in  1  synchronous clear of err.
- gnt  out  N_REQ  one-hot grant; high for one cycle.
- j  out  WIDTH  bank j inputs; registered.
- k  out  WIDTH  bank k inputs; registered.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle completion pulse.
- done_id  out  ID_W  requester id for the current done pulse.
- err  out  1  sticky error flag.

## Operation
- State machine has three states: IDLE, APPLY, CHECK.
  - IDLE -> APPLY when any req is high; otherwise stay in IDLE.
  - APPLY -> CHECK unconditionally.
  - CHECK -> IDLE unconditionally.
- Arbitration runs only in IDLE.
  - Round-robin search starts at pointer ptr and wraps modulo N_REQ.
  - The first requester with req high wins; call it w.
  - On the grant edge: ptr <= (w+1) mod N_REQ, gnt[w] <= 1, and w, op[w] and idx[w] are captured.
  - Requester inputs are ignored after capture.
- APPLY:
  - j/k drive only the captured idx bit: hold 0/0, clear 0/1, set 1/0, toggle 1/1.
  - Every other j/k bit is 0.
  - q[idx] is also captured as old.
- CHECK:
  - j/k are all 0.
  - Expected value: old for hold, 0 for clear, 1 for set, ~old for toggle.
  - q[idx] is compared with the expected value. On mismatch, err <= 1 on the edge leaving CHECK.
  - On the same edge: done <= 1 and done_id <= w.
- Illegal index (idx >= WIDTH): no j/k bit is asserted in APPLY. err is set when leaving CHECK; done still pulses.
- err is sticky: cleared only by reset or by clr_err sampled high. If clr_err and a new error occur on the same edge, the set wins.
- Withdrawing req before it is granted is legal; that request is simply never serviced.
- Reset (asynchronous assertion) immediately forces:
  - state IDLE, ptr 0;
  - gnt, j, k, done, err all 0;
  - done_id 0, busy 0.
- Reset mid-operation abandons the operation with no done pulse. The bank may or may not have sampled j/k; that is not checked.

## Timing
- Cycle T (IDLE): req sampled. gnt is visible in T+1 and lasts one cycle only.
- T+1 (APPLY): j/k are valid. The bank samples them at the end of T+1.
- T+2 (CHECK): q reflects the new value and is compared.
- T+3: done pulse visible. State is IDLE again and can accept a new request in this same cycle.
- Throughput: one operation per 3 cycles. Grant-to-done latency: 2 cycles.
- busy is high in T+1 and T+2, and low in T+3.
- A requester granted in T+1 may reassert req in T+2. It is not serviced before the other pending requesters, because the pointer has moved past it.
- Simultaneous requests: exactly one grant per arbitration. No request starves: it waits at most N_REQ-1 other grants.

## Test plan
- Single set: reset, bank q=00, requester 2 op=10 idx=5.
  - Expect gnt=0100 for one cycle; then j=0x20, k=0x00 for one cycle.
  - Then done=1 with done_id=2; err=0.
- Toggle then hold on bit 0, issued back to back from requester 0.
  - Expect q[0] to go 0 -> 1 and then stay 1.
  - Expect two done pulses, 3 cycles apart; err=0.
- Fairness: all four req held high continuously for 8 operations.
  - Expect grant order 0,1,2,3,0,1,2,3.
  - Expect each gnt exactly 3 cycles apart.
- Error detection and clear:
  - Bench bank ignores j/k and holds q[3]=0 while op=set idx=3 runs. Expect err=1 after done.
  - Pulse clr_err. Expect err=0 on the next cycle.
- Illegal index, with WIDTH=6: idx=7.
  - Expect j=k=0 throughout and a done pulse.
  - Expect err=1.
- Reset mid-operation: assert reset during APPLY.
  - Expect j, k, gnt, busy, done to go 0 immediately, with no done pulse.
  - After release, requester 0 is granted first (ptr=0).
